// File: rtl/btb_update_ctrl_pkg.sv
// Shared BTB definitions: table geometry and the update record.
// Imported by the BTB and by its update controller.
package btb_update_ctrl_pkg;

  localparam int BTB_SIZE     = 64;
  localparam int BTB_IDX_BITS = 6;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
  } upd_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } btb_ctl_state_t;

endpackage

// File: rtl/btb_update_ctrl_fifo.sv
// Update queue: two push slots (slot 0 older), one pop,
// occupancy count and a synchronous clear.
module btb_upd_fifo
  import btb_update_ctrl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push0,
  input  upd_entry_t    data0,
  input  logic          push1,
  input  upd_entry_t    data1,
  input  logic          pop,
  output upd_entry_t    head,
  output logic [AW:0]   count
);

  upd_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr1;
  logic [AW:0]   push_n;

  assign wr_ptr1 = wr_ptr + AW'(1);
  assign push_n  = (AW+1)'(push0) + (AW+1)'(push1);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= data0;
    if (push1) mem[wr_ptr1] <= data1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_n[AW-1:0];
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + push_n - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// Schedules EX/ID updates and invalidate walks onto the single
// BTB write port; all btb_* outputs are registered.
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
#(
  parameter int SIZE       = BTB_SIZE,
  parameter int IDX_BITS   = BTB_IDX_BITS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_upd_valid,
  input  logic [31:0]         ex_upd_pc,
  input  logic [31:0]         ex_upd_target,
  output logic                ex_upd_ready,
  input  logic                id_upd_valid,
  input  logic [31:0]         id_upd_pc,
  input  logic [31:0]         id_upd_target,
  output logic                id_upd_ready,
  input  logic                flush_req,
  output logic                flush_busy,
  output logic                btb_update_en,
  output logic [31:0]         btb_pc_update,
  output logic [31:0]         btb_target_update,
  output logic                btb_inv_en,
  output logic [IDX_BITS-1:0] btb_inv_index,
  output logic                btb_query_block
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_BITS:0] LAST = (IDX_BITS+1)'(SIZE - 1);
  localparam logic [IDX_BITS:0] ONE  = (IDX_BITS+1)'(1);

  btb_ctl_state_t    state, state_nxt;
  logic [IDX_BITS:0] cnt, cnt_nxt;
  logic [CW-1:0]     count, free;
  logic              run_ok, empty, ex_acc, id_acc;
  logic              push0, push1, pop, wr_nxt;
  upd_entry_t        ex_e, id_e, first_e, head, d0, wr_e;

  assign ex_e  = '{pc: ex_upd_pc, target: ex_upd_target};
  assign id_e  = '{pc: id_upd_pc, target: id_upd_target};
  assign free  = CW'(FIFO_DEPTH) - count;
  assign empty = (count == '0);

  assign run_ok       = !rst && state == RUN && !flush_req;
  assign ex_upd_ready = run_ok && free != '0;
  assign id_upd_ready = run_ok && (free >= CW'(2) ||
                        (free != '0 && !ex_upd_valid));
  assign ex_acc = ex_upd_valid && ex_upd_ready;
  assign id_acc = id_upd_valid && id_upd_ready;

  // With an empty queue the oldest accepted request bypasses it,
  // giving a write strobe in the very next cycle.
  assign first_e = ex_acc ? ex_e : id_e;
  assign push0   = empty ? (ex_acc && id_acc) : (ex_acc || id_acc);
  assign d0      = empty ? id_e : first_e;
  assign push1   = !empty && ex_acc && id_acc;
  assign pop     = run_ok && !empty;
  assign wr_nxt  = run_ok && (!empty || ex_acc || id_acc);
  assign wr_e    = empty ? first_e : head;

  btb_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_req),
    .push0 (push0),
    .data0 (d0),
    .push1 (push1),
    .data1 (id_e),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (flush_req) begin
          state_nxt = FLUSH;
          cnt_nxt   = '0;
        end
      end
      FLUSH: begin
        if (flush_req) begin
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Outputs track the next state so the strobe lines up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_update_en     <= 1'b0;
      btb_pc_update     <= '0;
      btb_target_update <= '0;
      btb_inv_en        <= 1'b0;
      btb_inv_index     <= '0;
      flush_busy        <= 1'b0;
    end else begin
      btb_update_en <= wr_nxt;
      if (wr_nxt) begin
        btb_pc_update     <= wr_e.pc;
        btb_target_update <= wr_e.target;
      end
      btb_inv_en    <= (state_nxt == FLUSH);
      btb_inv_index <= cnt_nxt[IDX_BITS-1:0];
      flush_busy    <= (state_nxt == FLUSH);
    end
  end

  assign btb_query_block = flush_busy;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: vector table, directed flush/reset
// sequences and random traffic against a queue-based model.
module tb_btb_update_ctrl;
  import btb_update_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_upd_valid, id_upd_valid, flush_req;
  logic [31:0] ex_upd_pc, ex_upd_target, id_upd_pc, id_upd_target;
  logic        ex_upd_ready, id_upd_ready, flush_busy;
  logic        btb_update_en, btb_inv_en, btb_query_block;
  logic [31:0] btb_pc_update, btb_target_update;
  logic [5:0]  btb_inv_index;

  always #5 clk = ~clk;

  btb_update_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .ex_upd_valid      (ex_upd_valid),
    .ex_upd_pc         (ex_upd_pc),
    .ex_upd_target     (ex_upd_target),
    .ex_upd_ready      (ex_upd_ready),
    .id_upd_valid      (id_upd_valid),
    .id_upd_pc         (id_upd_pc),
    .id_upd_target     (id_upd_target),
    .id_upd_ready      (id_upd_ready),
    .flush_req         (flush_req),
    .flush_busy        (flush_busy),
    .btb_update_en     (btb_update_en),
    .btb_pc_update     (btb_pc_update),
    .btb_target_update (btb_target_update),
    .btb_inv_en        (btb_inv_en),
    .btb_inv_index     (btb_inv_index),
    .btb_query_block   (btb_query_block)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference model: a plain queue of pending writes plus a walk index.
  upd_entry_t  q[$];
  bit          m_run;
  int          m_idx;
  bit          e_en, e_inv, e_busy;
  logic [31:0] e_pc, e_tgt;
  int          e_idx;
  int          n_inv, n_upd;
  bit          mon_on = 1'b0;

  task automatic m_reset();
    q.delete();
    m_run = 1'b1;
    m_idx = 0;
    e_en = 0; e_pc = 0; e_tgt = 0;
    e_inv = 0; e_idx = 0; e_busy = 0;
  endtask

  always @(negedge clk) begin
    int         free;
    bit         er, ir;
    upd_entry_t e;
    if (mon_on) begin
      if (rst) m_reset();
      chk("update_en", 32'(btb_update_en), 32'(e_en));
      if (e_en) begin
        chk("pc_update", btb_pc_update, e_pc);
        chk("target_update", btb_target_update, e_tgt);
      end
      chk("inv_en", 32'(btb_inv_en), 32'(e_inv));
      if (e_inv) chk("inv_index", 32'(btb_inv_index), 32'(e_idx));
      chk("flush_busy", 32'(flush_busy), 32'(e_busy));
      chk("query_block", 32'(btb_query_block), 32'(e_busy));
      if (btb_inv_en) n_inv++;
      if (btb_update_en) n_upd++;
      free = 4 - q.size();
      er = !rst && m_run && !flush_req && free >= 1;
      ir = !rst && m_run && !flush_req &&
           (free >= 2 || (free >= 1 && !ex_upd_valid));
      chk("ex_ready", 32'(ex_upd_ready), 32'(er));
      chk("id_ready", 32'(id_upd_ready), 32'(ir));
      if (rst) begin
        m_reset();
      end else if (flush_req) begin
        q.delete();
        m_run = 0; m_idx = 0;
        e_en = 0; e_inv = 1; e_idx = 0; e_busy = 1;
      end else if (!m_run) begin
        e_en = 0;
        if (m_idx == 63) begin
          m_run = 1; e_inv = 0; e_busy = 0;
        end else begin
          m_idx++;
          e_idx = m_idx;
        end
      end else begin
        if (ex_upd_valid && er) q.push_back('{ex_upd_pc, ex_upd_target});
        if (id_upd_valid && ir) q.push_back('{id_upd_pc, id_upd_target});
        if (q.size() > 0) begin
          e = q.pop_front();
          e_en = 1; e_pc = e.pc; e_tgt = e.target;
        end else begin
          e_en = 0;
        end
      end
    end
  end

  typedef struct {
    logic        exv;
    logic [31:0] expc, extg;
    logic        idv;
    logic [31:0] idpc, idtg;
    logic        xr, ir, en;
    logic [31:0] pc, tg;
  } vec_t;

  vec_t vt[7];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_upd_valid = 0; id_upd_valid = 0; flush_req = 0;
  endtask

  task automatic both(input logic [31:0] b);
    ex_upd_valid = 1; ex_upd_pc = b; ex_upd_target = b + 32'h100;
    id_upd_valid = 1; id_upd_pc = b + 4; id_upd_target = b + 32'h200;
  endtask

  task automatic drive_rand(input int n, input int pv, input int pf);
    bit ea = 1'b1, ia = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (!ex_upd_valid || ea) begin
        ex_upd_valid = ($urandom_range(0, 99) < pv);
        ex_upd_pc = $urandom; ex_upd_target = $urandom;
      end
      if (!id_upd_valid || ia) begin
        id_upd_valid = ($urandom_range(0, 99) < pv);
        id_upd_pc = $urandom; id_upd_target = $urandom;
      end
      flush_req = ($urandom_range(0, 99) < pf);
      @(negedge clk);
      ea = ex_upd_valid && ex_upd_ready;
      ia = id_upd_valid && id_upd_ready;
      cyc();
    end
    idle();
  endtask

  task automatic wait_idx(input int k);
    bit hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (btb_inv_en && btb_inv_index == 6'(k)) hit = 1;
      else cyc();
    end
    chk("wait_index_found", 32'(hit), 32'd1);
  endtask

  initial begin
    idle();
    ex_upd_pc = 0; ex_upd_target = 0; id_upd_pc = 0; id_upd_target = 0;
    rst = 1;
    m_reset();
    mon_on = 1;
    #2;
    chk("reset_ex_ready", 32'(ex_upd_ready), 0);
    chk("reset_update_en", 32'(btb_update_en), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    vt[0] = '{1, 32'h1004, 32'h2000, 0, 0, 0, 1, 1, 0, 0, 0};
    vt[1] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h1004, 32'h2000};
    vt[2] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    vt[3] = '{1, 32'hA0, 32'hB0, 1, 32'hC0, 32'hD0, 1, 1, 0, 0, 0};
    vt[4] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 32'hA0, 32'hB0};
    vt[5] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 32'hC0, 32'hD0};
    vt[6] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      ex_upd_valid = vt[i].exv;
      ex_upd_pc = vt[i].expc; ex_upd_target = vt[i].extg;
      id_upd_valid = vt[i].idv;
      id_upd_pc = vt[i].idpc; id_upd_target = vt[i].idtg;
      @(negedge clk);
      chk("vec_ex_ready", 32'(ex_upd_ready), 32'(vt[i].xr));
      chk("vec_id_ready", 32'(id_upd_ready), 32'(vt[i].ir));
      chk("vec_update_en", 32'(btb_update_en), 32'(vt[i].en));
      if (vt[i].en) begin
        chk("vec_pc", btb_pc_update, vt[i].pc);
        chk("vec_target", btb_target_update, vt[i].tg);
      end
      cyc();
    end
    idle();

    // Saturate the queue with dual requests, then drain.
    drive_rand(10, 100, 0);
    repeat (6) cyc();

    // Flush with three entries pending.
    both(32'h3000); cyc();
    both(32'h3100); cyc();
    both(32'h3200); cyc();
    idle(); flush_req = 1; cyc();
    flush_req = 0; n_inv = 0; n_upd = 0;
    repeat (70) cyc();
    chk("flush_inv_cycles", 32'(n_inv), 32'd64);
    chk("flush_no_update", 32'(n_upd), 32'd0);
    chk("flush_busy_after", 32'(flush_busy), 0);
    chk("ready_after_walk", 32'(ex_upd_ready), 1);

    // Re-pulse at index 30.
    flush_req = 1; cyc();
    flush_req = 0; n_inv = 0;
    wait_idx(29);
    cyc();
    flush_req = 1; cyc();
    flush_req = 0;
    repeat (80) cyc();
    chk("repulse_inv_cycles", 32'(n_inv), 32'd95);

    // Asynchronous reset mid-walk.
    flush_req = 1; cyc();
    flush_req = 0;
    wait_idx(16);
    cyc();
    chk("pre_reset_index", 32'(btb_inv_index), 32'd17);
    #1 rst = 1;
    #1;
    chk("rst_inv_en", 32'(btb_inv_en), 0);
    chk("rst_inv_index", 32'(btb_inv_index), 0);
    chk("rst_busy", 32'(flush_busy), 0);
    chk("rst_qblock", 32'(btb_query_block), 0);
    chk("rst_id_ready", 32'(id_upd_ready), 0);
    cyc();
    rst = 0;
    @(negedge clk);
    chk("post_rst_ex_ready", 32'(ex_upd_ready), 1);
    cyc();

    drive_rand(400, 60, 2);
    repeat (80) cyc();
    chk("final_queue_empty", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Scheduler in front of the branch target buffer's single write port.
- Accepts resolved-branch updates from two requesters: EX (branch resolution) and ID (direct jump decode). Buffers them in a small FIFO and drains one write per cycle to the BTB.
- Sequences a full-table invalidate walk on a flush request (fence.i / context change), and blocks BTB hits while the walk is in progress.

Parameters:
- SIZE, 64, number of BTB entries.
- IDX_BITS, 6, log2(SIZE); width of the invalidate index.
- FIFO_DEPTH, 4, update queue entries (power of two, at least 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- ex_upd_valid  in  1  EX requests a BTB update.
- ex_upd_pc  in  32  PC of the resolved branch.
- ex_upd_target  in  32  resolved target.
- ex_upd_ready  out  1  EX update accepted this cycle when valid&ready.
- id_upd_valid  in  1  ID requests a BTB update.
- id_upd_pc  in  32  PC of the decoded jump.
- id_upd_target  in  32  jump target.
- id_upd_ready  out  1  ID update accepted when valid&ready.
- flush_req  in  1  single-cycle pulse; invalidate the whole BTB.
- flush_busy  out  1  invalidate walk in progress.
- btb_update_en  out  1  BTB write strobe.
- btb_pc_update  out  32  PC to write.
- btb_target_update  out  32  target to write.
- btb_inv_en  out  1  clear valid bit of entry btb_inv_index.
- btb_inv_index  out  IDX_BITS  entry being invalidated.
- btb_query_block  out  1  forces BTB hit to 0 (equals flush_busy).

Behaviour:
- Reset (async, rst=1):
  - all outputs 0; FIFO empty; state RUN; walk counter 0.
  - Ready outputs are 0 during reset. They go high in the first cycle after release, once the FIFO is empty and the state is RUN.
- All btb_* outputs are registered.
- FSM states are RUN and FLUSH.
- RUN, enqueue:
  - free = FIFO_DEPTH - count.
  - ex_upd_ready = (free >= 1).
  - id_upd_ready = (free >= 2) or (free >= 1 and !ex_upd_valid). EX has priority.
  - Both accepted in the same cycle: EX is written first, ID second (EX is older in program order).
- RUN, dequeue:
  - If the FIFO is non-empty, pop the head each cycle.
  - Next cycle: btb_update_en=1, with btb_pc_update/btb_target_update = head contents.
  - Otherwise btb_update_en=0.
  - Latency: accept in cycle N gives the write strobe in cycle N+1 at the earliest.
- Same-cycle push and pop are both allowed; count is updated by push_count - pop.
- A full FIFO drops no request; the requester must hold valid until ready.
- Same-PC duplicates are not coalesced. The later entry wins because it is written later.
- flush_req in RUN:
  - Next state FLUSH; FIFO cleared (pending updates are stale, discarded); counter = 0.
  - A request presented in the same cycle as flush_req is not accepted (ready=0 that cycle).
- FLUSH:
  - Each cycle: btb_inv_en=1, btb_inv_index=counter, counter++.
  - Ready outputs = 0; btb_update_en = 0; flush_busy = btb_query_block = 1.
  - The walk takes exactly SIZE cycles of btb_inv_en.
  - After index SIZE-1 the next state is RUN and flush_busy drops in the following cycle.
- flush_req during FLUSH: the counter restarts at 0 and the walk is again SIZE cycles from that point.
- Counter arithmetic is IDX_BITS+1 wide so the terminal compare (counter == SIZE-1) has no wrap ambiguity.
- Reset asserted mid-walk or mid-drain: immediate return to the reset state. Partially written entries are the BTB's concern; invalid entries remain invalid.

Decomposition:
- Shared package: BTB_SIZE, BTB_IDX_BITS, and the upd_entry_t struct {pc[31:0], target[31:0]}. The BTB and this controller both import it.
- One sub-module, btb_upd_fifo: a synchronous FIFO with a 2-push/1-pop port pair, count output and a synchronous clear.
- The FSM and the invalidate counter stay in the top module.

Test Plan:
- Single EX update pc=0x0000_1004, tgt=0x0000_2000 in cycle N → btb_update_en=1 in N+1 with those values, and 0 in N+2.
- EX and ID valid in the same cycle with the FIFO empty → both accepted; writes in N+1 (EX pc) and N+2 (ID pc), in that order.
- Fill the FIFO with 4 EX updates while the drain is ongoing:
  - ex_upd_ready deasserts only when count=4.
  - No update is lost; writes appear in acceptance order.
- flush_req with 3 entries queued:
  - no further btb_update_en;
  - btb_inv_en high for exactly 64 cycles with indices 0..63;
  - flush_busy low afterwards; the FIFO is empty.
- flush_req re-pulsed at walk index 30 → the index restarts at 0; total btb_inv_en cycles = 31 + 64.
- rst asserted asynchronously mid-walk (index 17) → all outputs 0 immediately; after release the state is RUN and ex_upd_ready=1.
